// File: rtl/imem_loader_arb_if.sv
// Handshake and bus signals between the instruction-memory loader/arbiter and its surroundings.
// slave = arbiter side, master = core/memory/byte-source side.
interface imem_loader_arb_if #(
    parameter int ADDR_W = 11
);
    logic              i_ld_start;
    logic [ADDR_W:0]   i_ld_len;
    logic              i_ld_valid;
    logic [7:0]        i_ld_data;
    logic              o_ld_ready;
    logic [31:0]       i_fetch_pc;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_mem_we;
    logic              o_core_stall;
    logic              o_core_flush;
    logic              o_pc_reset;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_ld_start, i_ld_len, i_ld_valid, i_ld_data, i_fetch_pc,
        output o_ld_ready, o_mem_addr, o_mem_wdata, o_mem_we, o_core_stall,
        output o_core_flush, o_pc_reset, o_busy, o_done, o_err
    );

    modport master (
        output i_ld_start, i_ld_len, i_ld_valid, i_ld_data, i_fetch_pc,
        input  o_ld_ready, o_mem_addr, o_mem_wdata, o_mem_we, o_core_stall,
        input  o_core_flush, o_pc_reset, o_busy, o_done, o_err
    );
endinterface

// File: rtl/imem_loader_arb.sv
// Instruction-memory port arbiter: fetch PC pass-through, or boot-load of a little-endian byte stream.
// Ready one cycle after start; 5 cycles/word (4 bytes + write); bytes held by the source while o_ld_ready is low.
module imem_loader_arb #(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    imem_loader_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W:0]   words_left;
    logic              err_q;

    logic start_ok, start_bad, xfer;

    assign start_ok  = (state_q == RUN) && bus.i_ld_start &&
                       (bus.i_ld_len != '0) && (bus.i_ld_len <= DEPTH_L);
    assign start_bad = (state_q == RUN) && bus.i_ld_start && (bus.i_ld_len > DEPTH_L);
    assign xfer      = (state_q == LOAD) && bus.i_ld_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.o_mem_addr   = bus.i_fetch_pc[ADDR_W+1:2];
        bus.o_mem_wdata  = asm_word;
        bus.o_mem_we     = 1'b0;
        bus.o_ld_ready   = 1'b0;
        bus.o_core_stall = 1'b0;
        bus.o_core_flush = 1'b0;
        bus.o_pc_reset   = 1'b0;
        bus.o_busy       = 1'b0;
        bus.o_done       = 1'b0;
        bus.o_err        = err_q;
        case (state_q)
            RUN: begin
                if (start_ok) state_d = LOAD;
            end
            LOAD: begin
                bus.o_mem_addr   = word_addr;
                bus.o_ld_ready   = 1'b1;
                bus.o_core_stall = 1'b1;
                bus.o_busy       = 1'b1;
                if (xfer && byte_cnt == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                bus.o_mem_addr   = word_addr;
                bus.o_mem_we     = 1'b1;
                bus.o_core_stall = 1'b1;
                bus.o_busy       = 1'b1;
                state_d          = (words_left == (ADDR_W+1)'(1)) ? FLUSH : LOAD;
            end
            FLUSH: begin
                bus.o_core_flush = 1'b1;
                bus.o_pc_reset   = 1'b1;
                bus.o_busy       = 1'b1;
                bus.o_done       = 1'b1;
                state_d          = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // word_addr never wraps into a live write: the length check caps a load at DEPTH_WORDS.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt   <= '0;
            asm_word   <= '0;
            word_addr  <= '0;
            words_left <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                byte_cnt   <= '0;
                word_addr  <= '0;
                words_left <= bus.i_ld_len;
                err_q      <= 1'b0;
            end else if (start_bad) begin
                err_q <= 1'b1;
            end
            if (xfer) begin
                asm_word[8*byte_cnt +: 8] <= bus.i_ld_data;
                byte_cnt                  <= byte_cnt + 2'd1;
            end
            if (state_q == WRITE) begin
                word_addr  <= word_addr + ADDR_W'(1);
                words_left <= words_left - (ADDR_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_loader_arb.sv
// Bench for imem_loader_arb: RUN-state vector table, fixed and randomized loads against a word/byte reference model.
module tb_imem_loader_arb;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clk = ~i_clk;

    imem_loader_arb_if #(.ADDR_W(AW)) bus();

    imem_loader_arb #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic        start;
        logic [AW:0] len;
        logic [31:0] pc;
        logic [AW-1:0] exp_addr;
        logic        exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    wr_t         exp_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] load_words[$];
    logic [31:0] mem_model [DEPTH];
    int mode, cyc, first_cyc, done_cyc, done_cnt, wr_cnt;
    bit tog, expect_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        wr_t w;
        if (expect_ready) begin
            chk("start_latency_ready", 32'(bus.o_ld_ready), 32'd1);
            first_cyc    = cyc;
            expect_ready = 1'b0;
        end
        if (bus.o_mem_we) begin
            wr_cnt++;
            chk("ready_low_in_write", 32'(bus.o_ld_ready), 32'd0);
            chk("stall_in_write", 32'(bus.o_core_stall), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", bus.o_mem_addr, bus.o_mem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("write_addr", 32'(bus.o_mem_addr), 32'(w.addr));
                chk("write_data", bus.o_mem_wdata, w.data);
            end
            mem_model[bus.o_mem_addr] = bus.o_mem_wdata;
        end
        if (bus.o_busy && !bus.o_done) chk("stall_held", 32'(bus.o_core_stall), 32'd1);
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("flush_at_done", {30'd0, bus.o_core_flush, bus.o_pc_reset}, 32'd3);
            chk("no_stall_in_flush", 32'(bus.o_core_stall), 32'd0);
            chk("flush_addr_from_pc", 32'(bus.o_mem_addr), 32'(bus.i_fetch_pc[AW+1:2]));
            chk("writes_left_at_done", 32'(exp_q.size()), 32'd0);
        end else begin
            chk("no_flush_outside_done", {30'd0, bus.o_core_flush, bus.o_pc_reset}, 32'd0);
        end
    endtask

    task automatic drive_src();
        if (byte_q.size() == 0) begin
            bus.i_ld_valid = 1'b0;
            bus.i_ld_start = 1'b0;
        end else begin
            bus.i_ld_data = byte_q[0];
            case (mode)
                0: bus.i_ld_valid = 1'b1;
                1: begin tog = ~tog; bus.i_ld_valid = tog; end
                default: bus.i_ld_valid = 1'($urandom_range(0, 1));
            endcase
            // Spurious starts while a load is in flight must be ignored.
            bus.i_ld_start = (mode == 2) && ($urandom_range(0, 3) == 0);
            if (bus.i_ld_start) bus.i_ld_len = (AW+1)'($urandom_range(1, 5));
        end
    endtask

    task automatic cycle();
        bit x;
        @(negedge i_clk);
        cyc++;
        monitor();
        x = bus.o_ld_ready && bus.i_ld_valid;
        @(posedge i_clk);
        #1;
        if (x) void'(byte_q.pop_front());
        drive_src();
    endtask

    task automatic begin_load(input int m, input logic [31:0] pc);
        logic [31:0] w;
        byte_q.delete();
        exp_q.delete();
        mode = m;
        tog  = 1'b0;
        bus.i_fetch_pc = pc;
        for (int i = 0; i < load_words.size(); i++) begin
            w = load_words[i];
            exp_q.push_back('{addr: AW'(i), data: w});
            for (int b = 0; b < 4; b++) byte_q.push_back(w[8*b +: 8]);
        end
        drive_src();
        bus.i_ld_start = 1'b1;
        bus.i_ld_len   = (AW+1)'(load_words.size());
        cycle();
        expect_ready = 1'b1;
    endtask

    task automatic run_load(input int m, input logic [31:0] pc);
        int d0, budget, len;
        len = load_words.size();
        d0  = done_cnt;
        begin_load(m, pc);
        budget = 40 * len + 20;
        while (done_cnt == d0 && budget > 0) begin
            cycle();
            budget--;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: no done after %0d-word load, got none, expected one pulse", len);
        end else if (m == 0) begin
            chk("flush_cycle_offset", 32'(done_cyc - first_cyc), 32'(5 * len));
        end
        chk("run_after_flush_busy", 32'(bus.o_busy), 32'd0);
        chk("run_after_flush_stall", 32'(bus.o_core_stall), 32'd0);
        chk("run_after_flush_addr", 32'(bus.o_mem_addr), 32'(pc[AW+1:2]));
    endtask

    vec_t vecs[6];

    initial begin
        int w0, budget, d0, n;
        logic [31:0] pc;
        vecs[0] = '{start: 1'b0, len: 12'd0,    pc: 32'h0000_0010, exp_addr: 11'd4,     exp_err: 1'b0};
        vecs[1] = '{start: 1'b1, len: 12'd0,    pc: 32'h0000_1FFC, exp_addr: 11'h7FF,   exp_err: 1'b0};
        vecs[2] = '{start: 1'b1, len: 12'd2049, pc: 32'h0000_2000, exp_addr: 11'd0,     exp_err: 1'b1};
        vecs[3] = '{start: 1'b1, len: 12'd0,    pc: 32'h0000_0014, exp_addr: 11'd5,     exp_err: 1'b1};
        vecs[4] = '{start: 1'b1, len: 12'd4095, pc: 32'hFFFF_FFFC, exp_addr: 11'h7FF,   exp_err: 1'b1};
        vecs[5] = '{start: 1'b0, len: 12'd0,    pc: 32'h0000_0008, exp_addr: 11'd2,     exp_err: 1'b1};

        bus.i_ld_start = 1'b0;
        bus.i_ld_len   = '0;
        bus.i_ld_valid = 1'b0;
        bus.i_ld_data  = '0;
        bus.i_fetch_pc = '0;
        #2;
        chk("rst_we", 32'(bus.o_mem_we), 32'd0);
        chk("rst_ready", 32'(bus.o_ld_ready), 32'd0);
        chk("rst_stall", 32'(bus.o_core_stall), 32'd0);
        chk("rst_flush", {30'd0, bus.o_core_flush, bus.o_pc_reset}, 32'd0);
        chk("rst_busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_wdata", bus.o_mem_wdata, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        foreach (vecs[i]) begin
            bus.i_fetch_pc = vecs[i].pc;
            bus.i_ld_start = vecs[i].start;
            bus.i_ld_len   = vecs[i].len;
            #1;
            chk("run_addr", 32'(bus.o_mem_addr), 32'(vecs[i].exp_addr));
            @(posedge i_clk);
            #1;
            bus.i_ld_start = 1'b0;
            chk("run_err", 32'(bus.o_err), 32'(vecs[i].exp_err));
            chk("run_idle", {28'd0, bus.o_ld_ready, bus.o_busy, bus.o_core_stall, bus.o_mem_we}, 32'd0);
        end

        load_words = '{32'h0000_0013, 32'h0010_0093};
        run_load(0, 32'h0000_0040);
        chk("err_cleared_by_start", 32'(bus.o_err), 32'd0);
        run_load(1, 32'h0000_0044);
        run_load(2, 32'h0000_0048);

        load_words = '{$urandom, $urandom, $urandom};
        d0 = done_cnt;
        w0 = wr_cnt;
        begin_load(0, 32'h0000_0100);
        budget = 200;
        while (wr_cnt - w0 < 2 && budget > 0) begin
            cycle();
            budget--;
        end
        if (wr_cnt - w0 < 2) begin
            checks++;
            errors++;
            $display("FAIL reset_seq_timeout: got %0d writes, expected 2", wr_cnt - w0);
        end
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_we", 32'(bus.o_mem_we), 32'd0);
        chk("arst_ready_stall", {30'd0, bus.o_ld_ready, bus.o_core_stall}, 32'd0);
        chk("arst_busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        chk("arst_wdata", bus.o_mem_wdata, 32'd0);
        byte_q.delete();
        exp_q.delete();
        bus.i_ld_valid = 1'b0;
        bus.i_ld_start = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("after_arst_addr", 32'(bus.o_mem_addr), 32'd64);
        chk("no_done_on_reset", 32'(done_cnt - d0), 32'd0);
        chk("mem_word0_kept", mem_model[0], load_words[0]);
        chk("mem_word1_kept", mem_model[1], load_words[1]);
        repeat (3) cycle();
        chk("idle_after_arst", 32'(bus.o_busy), 32'd0);

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 6);
            pc = {$urandom} & 32'hFFFF_FFFC;
            load_words.delete();
            for (int i = 0; i < n; i++) load_words.push_back($urandom);
            run_load($urandom_range(0, 2), pc);
        end

        load_words.delete();
        for (int i = 0; i < DEPTH; i++) load_words.push_back($urandom);
        w0 = wr_cnt;
        run_load(0, 32'h0000_0000);
        chk("full_depth_writes", 32'(wr_cnt - w0), 32'(DEPTH));
        chk("full_depth_last_word", mem_model[DEPTH-1], load_words[DEPTH-1]);
        chk("full_depth_first_word", mem_model[0], load_words[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader_arb.md
# imem_loader_arb

Arbiter and boot-load controller for the pipeline's instruction memory port. In normal operation it passes the fetch PC through as the memory read address. On a load command it stalls the core, assembles a little-endian byte stream into 32-bit words, and writes them sequentially from word 0. It then flushes the decode stage and requests a PC reset so the core restarts on the new program.

## Interface
- DEPTH_WORDS, 2048, instruction memory depth in words
- ADDR_W, 11, word-address width; equals clog2(DEPTH_WORDS)

- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_ld_start  in  1  one-cycle load command, sampled only in RUN
- i_ld_len  in  ADDR_W+1  number of words to load, sampled with i_ld_start
- i_ld_valid  in  1  byte-stream valid
- i_ld_data  in  8  byte-stream data
- o_ld_ready  out  1  loader accepts a byte this cycle
- i_fetch_pc  in  32  fetch-stage byte PC
- o_mem_addr  out  ADDR_W  memory word address
- o_mem_wdata  out  32  memory write data
- o_mem_we  out  1  memory write enable
- o_core_stall  out  1  stall fetch/decode
- o_core_flush  out  1  flush decode stage
- o_pc_reset  out  1  force PC to 0 on the next edge
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle pulse when a load completes
- o_err  out  1  sticky error, set when a start is rejected

## Operation
- FSM states: RUN, LOAD, WRITE, FLUSH. Reset state is RUN.
- Registers: byte_cnt (2 bits), asm_word (32 bits), word_addr (ADDR_W bits), words_left (ADDR_W+1 bits), o_err.

RUN
- o_mem_addr = i_fetch_pc[ADDR_W+1:2].
- o_mem_we = 0, o_ld_ready = 0, o_core_stall = 0, o_busy = 0.
- i_ld_start with 1 ≤ i_ld_len ≤ DEPTH_WORDS: go to LOAD, clear byte_cnt, word_addr = 0, words_left = i_ld_len, o_err = 0.
- i_ld_start with i_ld_len = 0: no action, stay in RUN, o_err unchanged.
- i_ld_start with i_ld_len > DEPTH_WORDS: o_err = 1, stay in RUN.

LOAD
- o_ld_ready = 1, o_core_stall = 1, o_busy = 1.
- o_mem_we = 0; o_mem_addr = word_addr.
- On a byte transfer (valid & ready): asm_word[8*byte_cnt+7 : 8*byte_cnt] = i_ld_data, then byte_cnt++.
- On the transfer where byte_cnt = 3: go to WRITE.

WRITE (exactly one cycle)
- o_mem_we = 1, o_mem_addr = word_addr, o_mem_wdata = asm_word.
- o_ld_ready = 0, o_core_stall = 1.
- On exit: word_addr++, words_left--.
- Next state is FLUSH if words_left was 1, otherwise LOAD.

FLUSH (exactly one cycle)
- o_core_stall = 0, o_core_flush = 1, o_pc_reset = 1, o_done = 1, o_busy = 1.
- o_mem_addr = i_fetch_pc[ADDR_W+1:2].
- Next state is RUN.

General rules
- i_ld_start is ignored outside RUN.
- Bytes presented while o_ld_ready = 0 are not consumed; the source must hold them.
- o_mem_wdata = asm_word in every state; it is meaningful only while o_mem_we = 1.

## Timing
- Reset values: o_mem_we 0, o_ld_ready 0, o_core_stall 0, o_core_flush 0, o_pc_reset 0, o_busy 0, o_done 0, o_err 0, asm_word 0.
- With reset deasserted and the FSM in RUN, o_mem_addr tracks i_fetch_pc.
- All control outputs are decoded from registered state. o_mem_addr is combinational from i_fetch_pc only in RUN and FLUSH.
- Start latency: i_ld_start high at edge N means o_ld_ready = 1 in the cycle after N.
- Minimum of 5 cycles per word (4 byte cycles + 1 write). Back-to-back bytes with valid held high incur no bubbles except the WRITE cycle.
- An N-word load with continuous valid: FLUSH occurs 5N cycles after the first LOAD cycle; RUN resumes the cycle after that.
- Reset asserted mid-load returns the FSM to RUN immediately. Words already written remain in memory, and no o_done is issued.
- At word_addr = DEPTH_WORDS-1, the final write cannot wrap, because i_ld_len is bounded to DEPTH_WORDS.

## Test plan
- Reset then RUN with i_fetch_pc = 0x0000_0010 -> o_mem_addr = 4, o_mem_we = 0, o_core_stall = 0.
- Start with len = 2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 at address 0 and 0x00100093 at address 1, each with we high for one cycle. Then one FLUSH cycle with o_core_flush = o_pc_reset = o_done = 1, then RUN.
- Same load with i_ld_valid toggling every other cycle -> identical writes. o_ld_ready is never high in WRITE, and o_core_stall is held continuously from the first LOAD cycle through WRITE of word 1.
- Start with len = 2049 -> o_err = 1, no state change, no writes. A later valid start clears o_err.
- Start with len = 0 -> no state change, o_err unchanged. Start pulses during LOAD -> ignored, and words_left is unaffected.
- Async reset asserted after 2 of 3 words -> outputs return to reset values immediately, no o_done. After reset, RUN resumes and memory words 0–1 hold the loaded data.
